// File: rtl/al_accel_cp_unit.sv
// al_accel_cp_unit -- compare-pool (max-pooling) stage of the accelerator datapath.
//
// Accepts one DW-bit sample per enabled cycle and tracks the running maximum
// of a window of POOL_SIZE samples. When the last sample of a window is
// accepted, the window maximum is presented on cp_do together with a one-cycle
// cp_vld pulse, and the next window starts automatically.
//
// Ports:
//   clk      in   rising-edge clock
//   resetn   in   synchronous reset, active HIGH despite the name
//   enb      in   stage enable; 0 stalls the unit (state held, cp_vld forced low)
//   cp_clr   in   synchronous abort of the current window (ignored while stalled)
//   cp_di    in   DW-bit input sample
//   cp_do    out  running max of the current window / result of the last window
//   cp_vld   out  one-cycle pulse: cp_do holds a completed window result
//   cp_cnt   out  samples accumulated in the current window (0..POOL_SIZE-1)
//   cp_empty out  no sample accepted since reset, clear or window completion
//
// Handshake: cp_vld is a pure valid pulse with no ready. The result is valid
// only in the cycle cp_vld=1; downstream must capture it then. Upstream has no
// ready either: a sample is consumed on every edge with enb=1 and cp_clr=0.
//
// Priority per rising edge: resetn > stall (enb=0) > cp_clr > sample accept.
// All outputs come straight from registers.

module al_accel_cp_unit #(
    parameter int DW        = 8,
    parameter int POOL_SIZE = 4,
    parameter bit SIGNED    = 1'b1,
    localparam int CW       = $clog2(POOL_SIZE + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enb,
    input  logic          cp_clr,
    input  logic [DW-1:0] cp_di,
    output logic [DW-1:0] cp_do,
    output logic          cp_vld,
    output logic [CW-1:0] cp_cnt,
    output logic          cp_empty
);

    logic [DW-1:0] max_q;
    logic [CW-1:0] cnt_q;
    logic          vld_q;
    logic          empty_q;

    // Candidate value for max_q when a sample is accepted.
    logic          di_greater;
    logic [DW-1:0] max_next;
    // The accepted sample closes the current window.
    logic          last_sample;

    always_comb begin
        di_greater = 1'b0;
        if (SIGNED) begin
            di_greater = $signed(cp_di) > $signed(max_q);
        end else begin
            di_greater = cp_di > max_q;
        end
    end

    always_comb begin
        max_next = max_q;
        // An empty window loads the sample directly: the held result of the
        // previous window (or the reset value) must never take part in the compare.
        if (empty_q || di_greater) begin
            max_next = cp_di;
        end
    end

    assign last_sample = (cnt_q == CW'(POOL_SIZE - 1));

    always_ff @(posedge clk) begin
        if (resetn) begin
            max_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            empty_q <= 1'b1;
        end else if (!enb) begin
            // Stall: everything holds except the pulse, which must not stretch.
            vld_q <= 1'b0;
        end else if (cp_clr) begin
            // Abort the window; max_q keeps the last visible value.
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            max_q <= max_next;
            if (last_sample) begin
                cnt_q   <= '0;
                vld_q   <= 1'b1;
                empty_q <= 1'b1;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
                vld_q   <= 1'b0;
                empty_q <= 1'b0;
            end
        end
    end

    assign cp_do    = max_q;
    assign cp_vld   = vld_q;
    assign cp_cnt   = cnt_q;
    assign cp_empty = empty_q;

endmodule

// File: tb/tb_al_accel_cp_unit.sv
// Bench for al_accel_cp_unit. Three instances share one stimulus stream:
// signed POOL_SIZE=4, unsigned POOL_SIZE=4 and signed POOL_SIZE=1.

module tb_al_accel_cp_unit;

    localparam int NI = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] di;

    logic [7:0] do_s, do_u, do_1;
    logic       vld_s, vld_u, vld_1;
    logic [2:0] cnt_s, cnt_u;
    logic [0:0] cnt_1;
    logic       emp_s, emp_u, emp_1;

    al_accel_cp_unit #(.DW(8), .POOL_SIZE(4), .SIGNED(1'b1)) dut (
        .clk(clk), .resetn(rst), .enb(en), .cp_clr(clr), .cp_di(di),
        .cp_do(do_s), .cp_vld(vld_s), .cp_cnt(cnt_s), .cp_empty(emp_s)
    );

    al_accel_cp_unit #(.DW(8), .POOL_SIZE(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .resetn(rst), .enb(en), .cp_clr(clr), .cp_di(di),
        .cp_do(do_u), .cp_vld(vld_u), .cp_cnt(cnt_u), .cp_empty(emp_u)
    );

    al_accel_cp_unit #(.DW(8), .POOL_SIZE(1), .SIGNED(1'b1)) dut_1 (
        .clk(clk), .resetn(rst), .enb(en), .cp_clr(clr), .cp_di(di),
        .cp_do(do_1), .cp_vld(vld_1), .cp_cnt(cnt_1), .cp_empty(emp_1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each window is kept as the list of its samples; the output is the max
    // over that list, or the last shown value while the window is empty.
    int         ps[NI] = '{4, 4, 1};
    bit         sg[NI] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] win_q[NI][$];
    logic [7:0] m_do[NI];
    bit         m_vld[NI];

    function automatic int val(input logic [7:0] x, input bit s);
        return s ? int'($signed(x)) : int'({24'd0, x});
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c, input logic [7:0] d);
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                win_q[k].delete();
                m_do[k]  = 8'h00;
                m_vld[k] = 1'b0;
            end else if (!e) begin
                m_vld[k] = 1'b0;
            end else if (c) begin
                win_q[k].delete();
                m_vld[k] = 1'b0;
            end else begin
                logic [7:0] best;
                win_q[k].push_back(d);
                best = win_q[k][0];
                foreach (win_q[k][j])
                    if (val(win_q[k][j], sg[k]) > val(best, sg[k])) best = win_q[k][j];
                m_do[k]  = best;
                m_vld[k] = (win_q[k].size() == ps[k]);
                if (m_vld[k]) win_q[k].delete();
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] o_do[NI];
        bit         o_vld[NI];
        bit         o_emp[NI];
        int         o_cnt[NI];
        o_do  = '{do_s, do_u, do_1};
        o_vld = '{vld_s, vld_u, vld_1};
        o_emp = '{emp_s, emp_u, emp_1};
        o_cnt = '{int'(cnt_s), int'(cnt_u), int'(cnt_1)};
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model_do[%0d]", k),    o_do[k],  m_do[k]);
            chk($sformatf("model_vld[%0d]", k),   o_vld[k], m_vld[k]);
            chk($sformatf("model_cnt[%0d]", k),   o_cnt[k], win_q[k].size());
            chk($sformatf("model_empty[%0d]", k), o_emp[k], win_q[k].size() == 0);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change after the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic cycle(input bit r, input bit e, input bit c, input logic [7:0] d);
        rst = r; en = e; clr = c; di = d;
        @(posedge clk);
        model_step(r, e, c, d);
        #1;
        check_all();
        @(negedge clk);
    endtask

    // ---------------- directed vector table (signed, POOL_SIZE=4) ----------------
    typedef struct {
        bit         r, e, c;
        logic [7:0] d;
        logic [7:0] x_do;
        int         x_cnt;
        bit         x_vld, x_emp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit e, input bit c, input logic [7:0] d,
                       input logic [7:0] xdo, input int xcnt, input bit xvld, input bit xemp);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.d = d;
        v.x_do = xdo; v.x_cnt = xcnt; v.x_vld = xvld; v.x_emp = xemp;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; di = 8'h00;

        //  r  e  c  di      do     cnt vld emp
        add(1, 1, 0, 8'h55, 8'h00, 0, 0, 1);   // reset with random-looking data
        add(1, 1, 0, 8'hAA, 8'h00, 0, 0, 1);
        add(0, 0, 0, 8'h33, 8'h00, 0, 0, 1);   // first edge after release (stalled)
        add(0, 1, 0, 8'h05, 8'h05, 1, 0, 0);   // signed window
        add(0, 1, 0, 8'hF0, 8'h05, 2, 0, 0);
        add(0, 1, 0, 8'h7F, 8'h7F, 3, 0, 0);
        add(0, 1, 0, 8'h10, 8'h7F, 0, 1, 1);
        add(0, 0, 0, 8'h00, 8'h7F, 0, 0, 1);   // pulse lasts one cycle
        add(0, 1, 0, 8'h20, 8'h20, 1, 0, 0);   // stall test
        add(0, 0, 0, 8'h7E, 8'h20, 1, 0, 0);
        add(0, 1, 0, 8'h30, 8'h30, 2, 0, 0);
        add(0, 1, 1, 8'hFF, 8'h30, 0, 0, 1);   // clear to start fresh
        add(0, 1, 0, 8'h40, 8'h40, 1, 0, 0);   // clear mid-window
        add(0, 1, 0, 8'h50, 8'h50, 2, 0, 0);
        add(0, 1, 1, 8'h7F, 8'h50, 0, 0, 1);
        add(0, 1, 1, 8'h7F, 8'h50, 0, 0, 1);
        add(0, 1, 0, 8'h01, 8'h01, 1, 0, 0);   // direct load after clear
        add(0, 0, 1, 8'h7F, 8'h01, 1, 0, 0);   // clear ignored while stalled
        add(0, 1, 1, 8'h00, 8'h01, 0, 0, 1);
        add(0, 1, 0, 8'h80, 8'h80, 1, 0, 0);   // back-to-back windows
        add(0, 1, 0, 8'h81, 8'h81, 2, 0, 0);
        add(0, 1, 0, 8'h82, 8'h82, 3, 0, 0);
        add(0, 1, 0, 8'h83, 8'h83, 0, 1, 1);
        add(0, 1, 0, 8'h01, 8'h01, 1, 0, 0);
        add(0, 1, 0, 8'h02, 8'h02, 2, 0, 0);
        add(0, 1, 0, 8'h03, 8'h03, 3, 0, 0);
        add(0, 1, 0, 8'h04, 8'h04, 0, 1, 1);
        add(0, 1, 0, 8'h10, 8'h10, 1, 0, 0);   // reset mid-window
        add(1, 1, 0, 8'h22, 8'h00, 0, 0, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].d);
            chk($sformatf("tbl_do[%0d]", i),    do_s,       vecs[i].x_do);
            chk($sformatf("tbl_cnt[%0d]", i),   int'(cnt_s), vecs[i].x_cnt);
            chk($sformatf("tbl_vld[%0d]", i),   vld_s,      vecs[i].x_vld);
            chk($sformatf("tbl_empty[%0d]", i), emp_s,      vecs[i].x_emp);
        end

        // Unsigned compare and tie handling; POOL_SIZE=1 pulses on every sample.
        cycle(0, 1, 0, 8'h7F);
        chk("uns_first_do", do_u, 8'h7F);
        chk("p1_vld", vld_1, 1'b1);
        chk("p1_do", do_1, 8'h7F);
        cycle(0, 1, 0, 8'h80);
        chk("uns_max_do", do_u, 8'h80);
        chk("sgn_max_do", do_s, 8'h7F);
        cycle(0, 1, 0, 8'h80);
        chk("uns_tie_do", do_u, 8'h80);
        chk("uns_tie_cnt", int'(cnt_u), 3);
        cycle(0, 1, 0, 8'h80);
        chk("uns_done_vld", vld_u, 1'b1);
        chk("uns_done_do", do_u, 8'h80);
        chk("uns_done_cnt", int'(cnt_u), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit         r, e, c;
            logic [7:0] d;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 4) != 0);
            c = ($urandom_range(0, 11) == 0);
            d = 8'($urandom_range(0, 255));
            cycle(r, e, c, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/al_accel_cp_unit.md
Name: al_accel_cp_unit

Overview:
- Compare-pool (max-pooling) unit in the accelerator datapath.
- Consumes one signed 8-bit sample per enabled cycle and keeps a running maximum over a window of POOL_SIZE samples.
- Emits the window maximum with a one-cycle valid pulse, then starts the next window automatically.
- cp_clr aborts and empties the current window; enb is a pipeline stall.

Parameters:
- DW, 8, sample and result width in bits.
- POOL_SIZE, 4, samples per pooling window (≥1).
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  synchronous, active-high reset: when 1 at a rising edge of clk, all state is cleared.
- enb  input  1  stage enable; 0 = stall, all state held.
- cp_clr  input  1  synchronous clear of the current window.
- cp_di  input  DW  input sample.
- cp_do  output  DW  running max of the current window; holds the final max after window completion until the next accepted sample.
- cp_vld  output  1  one-cycle pulse when a window completes.
- cp_cnt  output  clog2(POOL_SIZE+1)  samples accumulated in the current window.
- cp_empty  output  1  1 when no sample has been accepted since reset, clear, or window completion.

Behaviour:
- Priority, evaluated per rising edge: resetn > enb==0 > cp_clr > sample accept.
- Reset (resetn=1): cp_do=0, cp_cnt=0, cp_vld=0, cp_empty=1. Reset mid-window discards the partial window.
- Stall (enb=0):
  - cp_do, cp_cnt and cp_empty hold; cp_di is ignored; cp_clr is ignored.
  - cp_vld is forced to 0.
- Clear (enb=1, cp_clr=1):
  - cp_cnt=0, cp_empty=1, cp_vld=0; cp_do holds its last value.
  - cp_di that cycle is discarded.
  - A clear held over several cycles keeps the unit empty.
- Accept (enb=1, cp_clr=0): the sample is cp_di.
  - If cp_empty=1: cp_do←cp_di.
  - Else: cp_do←max(cp_do, cp_di), signed or unsigned per SIGNED. On a tie, cp_do is unchanged.
  - cp_cnt increments.
  - If the new count equals POOL_SIZE: cp_vld=1 next cycle, cp_cnt←0, cp_empty←1. cp_do keeps the window result, which is readable in the same cycle cp_vld=1.
  - Otherwise: cp_vld=0, cp_empty←0.
- Latency: one clock from an accepted sample to an updated cp_do/cp_vld. No combinational path from inputs to outputs; all outputs are registered.
- POOL_SIZE=1: every accepted sample pulses cp_vld with cp_do=cp_di.
- cp_cnt never exceeds POOL_SIZE-1 at an output sample point after the register update. It wraps through 0 on completion.
- cp_di X/unknown while enb=0 or cp_clr=1 must not affect state.

Test Plan:
- Reset (resetn=1 for ≥1 clk, enb=1, cp_di random) → cp_do=0, cp_cnt=0, cp_vld=0, cp_empty=1 throughout reset; outputs stay at those values on the first edge after release.
- Signed window, POOL_SIZE=4: samples 0x05, 0xF0 (−16), 0x7F, 0x10 → cp_do steps 0x05, 0x05, 0x7F, 0x7F. cp_vld=1 for exactly one cycle after the 4th sample, cp_do=0x7F, cp_cnt=0.
- Stall: 0x20 accepted; enb=0 for one cycle with cp_di=0x7E; then enb=1 with 0x30 → 0x7E ignored, cp_do=0x30, cp_cnt=2. cp_vld stays 0 during the stall.
- Clear mid-window: 0x40, 0x50 accepted; cp_clr=1 for 2 cycles; then 0x01 → cp_empty=1 during the clear, cp_do=0x01 after the next sample (direct load, not max with 0x50), cp_cnt=1.
- Back-to-back windows: 8 consecutive samples 0x80, 0x81, 0x82, 0x83, 0x01, 0x02, 0x03, 0x04 (signed) → cp_vld pulses after the 4th (cp_do=0x83) and after the 8th (cp_do=0x04). The second window starts fresh, with no carry-over from 0x83.
- Unsigned variant (SIGNED=0): samples 0x7F, 0x80 in the same window → cp_do=0x80. Tie case 0x80, 0x80 → cp_do=0x80, cnt advances normally.
